// File: rtl/fsm_lock_pkg.sv
// Shared definitions for the locked serial adder.
//   lock_state_t : operating modes of the key-match FSM
//   LFSR_TAPS    : feedback mask for the right-shifting Fibonacci LFSR
//                  implementing x^8+x^6+x^5+x^4+1 (bit positions 0,2,3,4)
//   key_sym()    : extracts 2-bit key symbol i from a packed key (symbol 0 in bits [1:0])
package fsm_lock_pkg;

  typedef enum logic [1:0] {
    LOCKED,
    UNLOCKED,
    DEAD
  } lock_state_t;

  localparam logic [7:0] LFSR_TAPS = 8'h1D;

  // Packed keys are zero-extended to 64 bits, which allows up to 32 symbols.
  function automatic logic [1:0] key_sym(input logic [63:0] key, input int unsigned i);
    return key[2*i +: 2];
  endfunction

endpackage

// File: rtl/lock_lfsr8.sv
// 8-bit Fibonacci LFSR providing locked-mode output noise.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset, loads SEED
//   step_en   : advance the register one step on this edge
//   noise_bit : current LSB of the register
// The register shifts right; the feedback bit enters at bit 7.
import fsm_lock_pkg::*;

module lock_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic step_en,
  output logic noise_bit
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (step_en) begin
      lfsr_q <= {^(lfsr_q & LFSR_TAPS), lfsr_q[7:1]};
    end
  end

  assign noise_bit = lfsr_q[0];

endmodule

// File: rtl/fsm_unlock_serial_adder.sv
// Locked 2-bit serial adder with word overflow detection.
// After reset the block is LOCKED and emits LFSR noise on outp. Presenting the
// KEY_LEN symbols of KEY on {line2,line1}, symbol 0 first, unlocks it; from then
// on it adds line1 and line2 as unsigned words, LSB first, WORD_W bits per word,
// and pulses overflw with the carry-out of each word's last bit.
//   clock   : rising-edge clock
//   reset   : asynchronous active-low reset
//   line1   : operand A bit / key symbol bit 0
//   line2   : operand B bit / key symbol bit 1
//   outp    : registered sum bit (unlocked) or noise (locked/dead)
//   overflw : registered word carry-out pulse; 0 unless unlocked
// Build option FSM_LOCKOUT_EN: MAX_FAILS mismatches after a partial key match
// send the block to DEAD, which only reset leaves.
import fsm_lock_pkg::*;

module fsm_unlock_serial_adder #(
  parameter int unsigned          KEY_LEN   = 8,
  parameter logic [2*KEY_LEN-1:0] KEY       = 16'h9C6B,
  parameter int unsigned          WORD_W    = 8,
  parameter logic [7:0]           LFSR_SEED = 8'hA5,
  parameter int unsigned          MAX_FAILS = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic line1,
  input  logic line2,
  output logic outp,
  output logic overflw
);

  localparam int unsigned KIW      = (KEY_LEN > 2) ? $clog2(KEY_LEN) : 1;
  localparam int unsigned BCW      = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [63:0] KEY64    = 64'(KEY);
  localparam logic [1:0]  KEY_SYM0 = key_sym(KEY64, 0);
  localparam logic [KIW-1:0] KEY_LAST = KIW'(KEY_LEN - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WORD_W - 1);

  // The fail counter is two bits wide, so a threshold outside 1..3 is unusable.
  if (MAX_FAILS < 1 || MAX_FAILS > 3) begin : g_max_fails_out_of_range
  end

  lock_state_t    state_q, state_d;
  logic [KIW-1:0] key_idx_q, key_idx_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic           carry_q, carry_d;
  logic           outp_d, overflw_d;
  logic [1:0]     sym;
  logic [1:0]     sum;
  logic           noise_bit;
  logic           lfsr_step;
`ifdef FSM_LOCKOUT_EN
  logic [1:0]     fail_q, fail_d;
`endif

  assign sym = {line2, line1};
  assign sum = {1'b0, line1} + {1'b0, line2} + {1'b0, carry_q};

  // The LFSR advances on every edge outside UNLOCKED, including the edge
  // that accepts the final key symbol.
  assign lfsr_step = (state_q != UNLOCKED);

  lock_lfsr8 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk      (clock),
    .rst_n    (reset),
    .step_en  (lfsr_step),
    .noise_bit(noise_bit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= LOCKED;
      key_idx_q <= '0;
      bit_cnt_q <= '0;
      carry_q   <= 1'b0;
      outp      <= 1'b0;
      overflw   <= 1'b0;
`ifdef FSM_LOCKOUT_EN
      fail_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      key_idx_q <= key_idx_d;
      bit_cnt_q <= bit_cnt_d;
      carry_q   <= carry_d;
      outp      <= outp_d;
      overflw   <= overflw_d;
`ifdef FSM_LOCKOUT_EN
      fail_q    <= fail_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    key_idx_d = key_idx_q;
    bit_cnt_d = bit_cnt_q;
    carry_d   = carry_q;
    outp_d    = noise_bit;
    overflw_d = 1'b0;
`ifdef FSM_LOCKOUT_EN
    fail_d    = fail_q;
`endif

    unique case (state_q)
      LOCKED: begin
        if (sym == key_sym(KEY64, 32'(key_idx_q))) begin
          if (key_idx_q == KEY_LAST) begin
            state_d   = UNLOCKED;
            key_idx_d = '0;
            carry_d   = 1'b0;
            bit_cnt_d = '0;
`ifdef FSM_LOCKOUT_EN
            fail_d    = '0;
`endif
          end else begin
            key_idx_d = key_idx_q + 1'b1;
          end
        end else begin
          // Only a restart on symbol 0 is recognised; longer prefix overlaps are not.
          key_idx_d = (sym == KEY_SYM0) ? KIW'(1) : '0;
`ifdef FSM_LOCKOUT_EN
          if (key_idx_q != '0) begin
            fail_d = fail_q + 1'b1;
            if (fail_q == 2'(MAX_FAILS - 1)) begin
              state_d = DEAD;
            end
          end
`endif
        end
      end

      UNLOCKED: begin
        outp_d = sum[0];
        if (bit_cnt_q == BIT_LAST) begin
          overflw_d = sum[1];
          carry_d   = 1'b0;
          bit_cnt_d = '0;
        end else begin
          carry_d   = sum[1];
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end

      DEAD: begin
      end

      default: begin
        state_d = LOCKED;
      end
    endcase
  end

endmodule
